// File: rtl/regfile_ckpt.sv
// Architectural register file plus rename (alias) table with a ring of branch
// checkpoints that can be restored on a mispredict instead of a full flush.
module regfile_ckpt #(
  parameter int NUM_RD  = 2,
  parameter int REG_BIT = 5,
  parameter int ROB_BIT = 4,
  parameter int NUM_CK  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        reg_en,
  input  logic                        reg_st,
  input  logic                        reg_rb,
  input  logic [NUM_RD*REG_BIT-1:0]   id_rs,
  output logic [NUM_RD*ROB_BIT-1:0]   id_src,
  output logic [NUM_RD*32-1:0]        id_val,
  input  logic                        id_rn_ena,
  input  logic [REG_BIT-1:0]          id_rn_rd,
  input  logic [ROB_BIT-1:0]          id_rn_idx,
  input  logic                        rob_wr_ena,
  input  logic [REG_BIT-1:0]          rob_wr_rd,
  input  logic [31:0]                 rob_wr_val,
  input  logic [ROB_BIT-1:0]          rob_wr_idx,
  input  logic                        ck_save,
  output logic [$clog2(NUM_CK)-1:0]   ck_tag,
  input  logic                        ck_free,
  input  logic                        ck_rs_ena,
  input  logic [$clog2(NUM_CK)-1:0]   ck_rs_tag,
  output logic                        ck_full,
  output logic                        ck_empty
);

  localparam int REG_SIZE = 1 << REG_BIT;
  localparam int CK_BIT   = $clog2(NUM_CK);

  logic [ROB_BIT-1:0] src  [REG_SIZE];
  logic [31:0]        val  [REG_SIZE];
  logic [ROB_BIT-1:0] snap [NUM_CK][REG_SIZE];
  logic [CK_BIT-1:0]  head;
  logic [CK_BIT-1:0]  tail;
  logic [CK_BIT:0]    count;

  logic commit, rename, stall, free_ok, save_ok;

  // Writes aimed at x0 are dropped here so x0 can never leave zero.
  assign commit   = rob_wr_ena && (rob_wr_rd != '0);
  assign rename   = id_rn_ena && (id_rn_rd != '0);
  assign stall    = !rdy || !reg_en || reg_st;
  assign ck_full  = (count == (CK_BIT+1)'(NUM_CK));
  assign ck_empty = (count == '0);
  assign free_ok  = ck_free && !ck_empty;
  assign save_ok  = ck_save && !ck_full;
  assign ck_tag   = tail;

  genvar gi;

  // Same-cycle bypass: an in-flight rename beats a matching commit.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [REG_BIT-1:0] r;
      logic               hit_rn, hit_wr;
      assign r      = id_rs[gi*REG_BIT +: REG_BIT];
      assign hit_rn = rename && (id_rn_rd == r);
      assign hit_wr = commit && (rob_wr_rd == r) && (rob_wr_idx == src[r]);
      assign id_src[gi*ROB_BIT +: ROB_BIT] = hit_rn ? id_rn_idx : (hit_wr ? '0 : src[r]);
      assign id_val[gi*32 +: 32]           = hit_wr ? rob_wr_val : val[r];
    end
  endgenerate

  // Post-commit, post-rename view of the alias table; also what a save captures.
  logic [ROB_BIT-1:0] src_upd [REG_SIZE];
  generate
    for (gi = 0; gi < REG_SIZE; gi++) begin : g_ent
      logic wr_clr;
      assign wr_clr = commit && (rob_wr_rd == REG_BIT'(gi)) && (src[gi] == rob_wr_idx);
      assign src_upd[gi] = (rename && id_rn_rd == REG_BIT'(gi)) ? id_rn_idx :
                           (wr_clr ? '0 : src[gi]);
    end
  endgenerate

  logic [NUM_CK-1:0] live, snap_hit;
  generate
    for (gi = 0; gi < NUM_CK; gi++) begin : g_ck
      logic [CK_BIT-1:0] off;
      assign off          = CK_BIT'(gi) - head;
      assign live[gi]     = ({1'b0, off} < count);
      assign snap_hit[gi] = commit && live[gi] && (snap[gi][rob_wr_rd] == rob_wr_idx);
    end
  endgenerate

  logic [CK_BIT-1:0] head_fr;
  logic              rs_hit, drop_all;
  logic [CK_BIT:0]   rs_count, nrm_count;

  assign head_fr   = head + CK_BIT'(free_ok);
  assign rs_hit    = commit && (snap[ck_rs_tag][rob_wr_rd] == rob_wr_idx);
  // Freeing the very slot being restored leaves the ring empty.
  assign drop_all  = free_ok && (head == ck_rs_tag);
  assign rs_count  = drop_all ? '0 : ({1'b0, CK_BIT'(ck_rs_tag - head_fr)} + (CK_BIT+1)'(1));
  assign nrm_count = count + (CK_BIT+1)'(save_ok) - (CK_BIT+1)'(free_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        src[i] <= '0;
        val[i] <= '0;
        for (int j = 0; j < NUM_CK; j++) snap[j][i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (reg_rb) begin
      if (commit) val[rob_wr_rd] <= rob_wr_val;
      for (int i = 0; i < REG_SIZE; i++) src[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (ck_rs_ena) begin
      if (commit) val[rob_wr_rd] <= rob_wr_val;
      for (int j = 0; j < NUM_CK; j++)
        if (snap_hit[j]) snap[j][rob_wr_rd] <= '0;
      for (int i = 0; i < REG_SIZE; i++)
        src[i] <= (rs_hit && rob_wr_rd == REG_BIT'(i)) ? '0 : snap[ck_rs_tag][i];
      head  <= head_fr;
      tail  <= ck_rs_tag + CK_BIT'(1);
      count <= rs_count;
    end else if (!stall) begin
      if (commit) val[rob_wr_rd] <= rob_wr_val;
      for (int j = 0; j < NUM_CK; j++)
        if (snap_hit[j]) snap[j][rob_wr_rd] <= '0;
      for (int i = 0; i < REG_SIZE; i++) src[i] <= src_upd[i];
      if (save_ok)
        for (int i = 0; i < REG_SIZE; i++) snap[tail][i] <= src_upd[i];
      head  <= head_fr;
      tail  <= tail + CK_BIT'(save_ok);
      count <= nrm_count;
    end
  end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Directed vector table for the rename/checkpoint scenarios, an async-reset
// abort sequence, then random traffic against a queue-based reference model.
module tb_regfile_ckpt;
  localparam int NUM_RD = 2, REG_BIT = 5, ROB_BIT = 4, NUM_CK = 4, CK_BIT = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic rdy, reg_en, reg_st, reg_rb;
  logic [NUM_RD*REG_BIT-1:0] id_rs;
  logic [NUM_RD*ROB_BIT-1:0] id_src;
  logic [NUM_RD*32-1:0]      id_val;
  logic                      id_rn_ena;
  logic [REG_BIT-1:0]        id_rn_rd;
  logic [ROB_BIT-1:0]        id_rn_idx;
  logic                      rob_wr_ena;
  logic [REG_BIT-1:0]        rob_wr_rd;
  logic [31:0]               rob_wr_val;
  logic [ROB_BIT-1:0]        rob_wr_idx;
  logic                      ck_save, ck_free, ck_rs_ena, ck_full, ck_empty;
  logic [CK_BIT-1:0]         ck_tag, ck_rs_tag;

  regfile_ckpt #(.NUM_RD(NUM_RD), .REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT), .NUM_CK(NUM_CK)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reg_en(reg_en), .reg_st(reg_st), .reg_rb(reg_rb),
    .id_rs(id_rs), .id_src(id_src), .id_val(id_val),
    .id_rn_ena(id_rn_ena), .id_rn_rd(id_rn_rd), .id_rn_idx(id_rn_idx),
    .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd), .rob_wr_val(rob_wr_val), .rob_wr_idx(rob_wr_idx),
    .ck_save(ck_save), .ck_tag(ck_tag), .ck_free(ck_free), .ck_rs_ena(ck_rs_ena),
    .ck_rs_tag(ck_rs_tag), .ck_full(ck_full), .ck_empty(ck_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Field order: rs0 rs1 | rn_ena rn_rd rn_idx | wr_ena wr_rd wr_val wr_idx |
  // save free rse rs_tag rb stall | e_src0 e_val0 e_src1 e_val1 e_tag e_full e_empty
  typedef struct {
    int rs0, rs1, rn_ena, rn_rd, rn_idx, wr_ena, wr_rd, wr_val, wr_idx;
    int save, free, rse, rs_tag, rb, stall;
    int e_src0, e_val0, e_src1, e_val1, e_tag, e_full, e_empty;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  task automatic drive(input int rs0, rs1, rn_ena, rn_rd, rn_idx, wr_ena, wr_rd, wr_val, wr_idx,
                       input int save, free, rse, rs_tag, rb, rd_ok, en_ok, st);
    id_rs      = {REG_BIT'(rs1), REG_BIT'(rs0)};
    id_rn_ena  = 1'(rn_ena);
    id_rn_rd   = REG_BIT'(rn_rd);
    id_rn_idx  = ROB_BIT'(rn_idx);
    rob_wr_ena = 1'(wr_ena);
    rob_wr_rd  = REG_BIT'(wr_rd);
    rob_wr_val = 32'(wr_val);
    rob_wr_idx = ROB_BIT'(wr_idx);
    ck_save    = 1'(save);
    ck_free    = 1'(free);
    ck_rs_ena  = 1'(rse);
    ck_rs_tag  = CK_BIT'(rs_tag);
    reg_rb     = 1'(rb);
    rdy        = 1'(rd_ok);
    reg_en     = 1'(en_ok);
    reg_st     = 1'(st);
  endtask

  // Reference model: plain tables plus a queue of live checkpoint tags (oldest first).
  logic [3:0]  m_src  [32];
  logic [31:0] m_val  [32];
  logic [3:0]  m_snap [4][32];
  int          m_live [$];
  int          m_tail;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_src[i] = '0;
      m_val[i] = '0;
      for (int j = 0; j < 4; j++) m_snap[j][i] = '0;
    end
    m_live.delete();
    m_tail = 0;
  endtask

  initial begin
    vecs[0]  = '{5,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,1};
    vecs[1]  = '{0,0, 1,0,3, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 0,0,1};
    vecs[2]  = '{0,5, 1,5,7, 0,0,0,0, 0,0,0,0,0,0, 0,0,7,0, 0,0,1};
    vecs[3]  = '{5,1, 0,0,0, 1,5,32'hDEADBEEF,7, 0,0,0,0,0,0, 0,32'hDEADBEEF,0,0, 0,0,1};
    vecs[4]  = '{5,1, 1,1,2, 0,0,0,0, 0,0,0,0,0,0, 0,32'hDEADBEEF,2,0, 0,0,1};
    vecs[5]  = '{1,2, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 2,0,0,0, 0,0,1};
    vecs[6]  = '{1,2, 1,1,5, 0,0,0,0, 0,0,0,0,0,0, 5,0,0,0, 1,0,0};
    vecs[7]  = '{1,2, 1,2,6, 0,0,0,0, 0,0,0,0,0,0, 5,0,6,0, 1,0,0};
    vecs[8]  = '{1,2, 0,0,0, 0,0,0,0, 0,0,1,0,0,0, 5,0,6,0, 1,0,0};
    vecs[9]  = '{1,2, 0,0,0, 0,0,0,0, 0,0,0,0,0,0, 2,0,0,0, 1,0,0};
    vecs[10] = '{3,1, 1,3,4, 0,0,0,0, 0,0,0,0,0,0, 4,0,2,0, 1,0,0};
    vecs[11] = '{3,1, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 4,0,2,0, 1,0,0};
    vecs[12] = '{3,1, 0,0,0, 1,3,32'h12345678,4, 0,0,0,0,0,0, 0,32'h12345678,2,0, 2,0,0};
    vecs[13] = '{3,1, 1,3,9, 0,0,0,0, 0,0,0,0,0,0, 9,32'h12345678,2,0, 2,0,0};
    vecs[14] = '{3,1, 0,0,0, 0,0,0,0, 0,0,1,1,0,0, 9,32'h12345678,2,0, 2,0,0};
    vecs[15] = '{3,1, 0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,32'h12345678,2,0, 2,0,0};
    vecs[16] = '{1,3, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 2,0,0,32'h12345678, 2,0,0};
    vecs[17] = '{1,7, 0,0,0, 1,7,32'hA5A5A5A5,3, 0,0,1,1,1,1, 2,0,0,0, 3,0,0};
    vecs[18] = '{1,7, 0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,32'hA5A5A5A5, 0,0,1};
    vecs[19] = '{3,5, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,32'h12345678,0,32'hDEADBEEF, 0,0,1};
    vecs[20] = '{0,0, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0,0, 1,0,0};
    vecs[21] = '{0,0, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0,0, 2,0,0};
    vecs[22] = '{0,0, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0,0, 3,0,0};
    vecs[23] = '{0,0, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0,0, 0,1,0};
    vecs[24] = '{0,0, 0,0,0, 0,0,0,0, 1,1,0,0,0,0, 0,0,0,0, 0,1,0};
    vecs[25] = '{0,0, 0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0,0, 0,0,0};
    vecs[26] = '{4,0, 1,4,5, 0,0,0,0, 0,0,0,0,0,1, 5,0,0,0, 1,1,0};
    vecs[27] = '{4,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 1,1,0};
    vecs[28] = '{4,0, 0,0,0, 0,0,0,0, 0,1,1,1,0,0, 0,0,0,0, 1,1,0};
    vecs[29] = '{4,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0, 2,0,1};

    drive(0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rs0, vecs[i].rs1, vecs[i].rn_ena, vecs[i].rn_rd, vecs[i].rn_idx,
            vecs[i].wr_ena, vecs[i].wr_rd, vecs[i].wr_val, vecs[i].wr_idx,
            vecs[i].save, vecs[i].free, vecs[i].rse, vecs[i].rs_tag, vecs[i].rb,
            1, 1, vecs[i].stall);
      @(negedge clk);
      chk($sformatf("v%0d_src0", i),  32'(id_src[3:0]),   vecs[i].e_src0);
      chk($sformatf("v%0d_val0", i),  id_val[31:0],       vecs[i].e_val0);
      chk($sformatf("v%0d_src1", i),  32'(id_src[7:4]),   vecs[i].e_src1);
      chk($sformatf("v%0d_val1", i),  id_val[63:32],      vecs[i].e_val1);
      chk($sformatf("v%0d_tag", i),   32'(ck_tag),        vecs[i].e_tag);
      chk($sformatf("v%0d_full", i),  32'(ck_full),       vecs[i].e_full);
      chk($sformatf("v%0d_empty", i), 32'(ck_empty),      vecs[i].e_empty);
      $display("vec %0d src0=%0d val0=%h src1=%0d val1=%h tag=%0d full=%0b empty=%0b",
               i, id_src[3:0], id_val[31:0], id_src[7:4], id_val[63:32], ck_tag, ck_full, ck_empty);
      @(posedge clk);
      #1;
    end

    // Async reset arriving while a save is requested: everything clears at once.
    drive(5,3, 0,0,0, 0,0,0,0, 1,0,0,0,0, 1,1,0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_val0", id_val[31:0], 32'h0);
    chk("arst_val1", id_val[63:32], 32'h0);
    chk("arst_tag", 32'(ck_tag), 32'h0);
    chk("arst_empty", 32'(ck_empty), 32'h1);
    @(posedge clk);
    #1;
    chk("arst_tag_hold", 32'(ck_tag), 32'h0);
    rst = 1'b0;
    $display("arst tag=%0d empty=%0b val0=%h", ck_tag, ck_empty, id_val[31:0]);
    model_reset();

    for (int n = 0; n < 400; n++) begin
      int rs [2];
      int rn_ena, rn_rd, rn_idx, wr_ena, wr_rd, wr_val, wr_idx;
      int save, free, rse, rs_tag, rb, rd_ok, en_ok, st;
      bit cm, stall, was_full, was_empty;
      logic [3:0]  es;
      logic [31:0] ev;

      rs[0]  = $urandom_range(0, 7);
      rs[1]  = $urandom_range(0, 7);
      rn_ena = $urandom_range(0, 1);
      rn_rd  = $urandom_range(0, 7);
      rn_idx = $urandom_range(1, 15);
      wr_ena = ($urandom_range(0, 2) != 0) ? 1 : 0;
      wr_rd  = $urandom_range(0, 7);
      wr_val = $urandom;
      wr_idx = (m_src[wr_rd] != 0 && $urandom_range(0, 1) == 1) ? int'(m_src[wr_rd])
                                                               : $urandom_range(1, 15);
      save   = ($urandom_range(0, 99) < 35) ? 1 : 0;
      free   = ($urandom_range(0, 99) < 25) ? 1 : 0;
      rse    = (m_live.size() > 0 && $urandom_range(0, 99) < 8) ? 1 : 0;
      rs_tag = (m_live.size() > 0) ? m_live[$urandom_range(0, m_live.size() - 1)] : 0;
      rb     = ($urandom_range(0, 99) < 2) ? 1 : 0;
      rd_ok  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      en_ok  = ($urandom_range(0, 11) != 0) ? 1 : 0;
      st     = ($urandom_range(0, 9) == 0) ? 1 : 0;
      drive(rs[0], rs[1], rn_ena, rn_rd, rn_idx, wr_ena, wr_rd, wr_val, wr_idx,
            save, free, rse, rs_tag, rb, rd_ok, en_ok, st);

      cm    = (wr_ena == 1) && (wr_rd != 0);
      stall = (rd_ok == 0) || (en_ok == 0) || (st == 1);

      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit hw;
        hw = cm && (rs[k] != 0) && (wr_rd == rs[k]) && (wr_idx == int'(m_src[rs[k]]));
        if (rs[k] == 0) es = '0;
        else if (rn_ena == 1 && rn_rd == rs[k]) es = 4'(rn_idx);
        else if (hw) es = '0;
        else es = m_src[rs[k]];
        ev = hw ? 32'(wr_val) : m_val[rs[k]];
        chk($sformatf("r%0d_src%0d", n, k), 32'(id_src[k*4 +: 4]), 32'(es));
        chk($sformatf("r%0d_val%0d", n, k), id_val[k*32 +: 32], ev);
      end
      chk($sformatf("r%0d_tag", n), 32'(ck_tag), 32'(m_tail));
      chk($sformatf("r%0d_full", n), 32'(ck_full), 32'(m_live.size() == 4));
      chk($sformatf("r%0d_empty", n), 32'(ck_empty), 32'(m_live.size() == 0));
      $display("rnd %0d rs=%0d/%0d src=%0d/%0d tag=%0d live=%0d rb=%0d rse=%0d save=%0d free=%0d stall=%0b",
               n, rs[0], rs[1], id_src[3:0], id_src[7:4], ck_tag, m_live.size(), rb, rse, save, free, stall);

      if (rb == 1) begin
        if (cm) m_val[wr_rd] = 32'(wr_val);
        for (int i = 0; i < 32; i++) m_src[i] = '0;
        m_live.delete();
        m_tail = 0;
      end else if (rse == 1) begin
        if (cm) begin
          m_val[wr_rd] = 32'(wr_val);
          foreach (m_live[q])
            if (m_snap[m_live[q]][wr_rd] == 4'(wr_idx)) m_snap[m_live[q]][wr_rd] = '0;
        end
        if (free == 1 && m_live.size() > 0) void'(m_live.pop_front());
        for (int i = 0; i < 32; i++) m_src[i] = m_snap[rs_tag][i];
        while (m_live.size() > 0 && m_live[$] != rs_tag) void'(m_live.pop_back());
        m_tail = (rs_tag + 1) % 4;
      end else if (!stall) begin
        was_full  = (m_live.size() == 4);
        was_empty = (m_live.size() == 0);
        if (cm) begin
          m_val[wr_rd] = 32'(wr_val);
          if (m_src[wr_rd] == 4'(wr_idx)) m_src[wr_rd] = '0;
          foreach (m_live[q])
            if (m_snap[m_live[q]][wr_rd] == 4'(wr_idx)) m_snap[m_live[q]][wr_rd] = '0;
        end
        if (rn_ena == 1 && rn_rd != 0) m_src[rn_rd] = 4'(rn_idx);
        if (save == 1 && !was_full) begin
          for (int i = 0; i < 32; i++) m_snap[m_tail][i] = m_src[i];
          m_live.push_back(m_tail);
          m_tail = (m_tail + 1) % 4;
        end
        if (free == 1 && !was_empty) void'(m_live.pop_front());
      end

      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
